fetch_queue: RTL and testbench

- Instruction buffer between ifetch_stage and the decode stage.
- Decouples icache-miss stalls from decode stalls.
- Holds up to DEPTH fetched {pc, instr} entries in a circular FIFO with valid/ready handshakes.
- Flushed on a taken branch so wrong-path instructions never reach decode.

---
 rtl/fetch_queue_pkg.sv | 20 ++
 rtl/fetch_queue_ff.sv | 22 ++
 rtl/fetch_queue.sv | 110 +++++++++++
 tb/tb_fetch_queue.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Holds the entry layout, the NOP filler and the default queue depth.
package fetch_queue_pkg;

   localparam int unsigned ILEN         = 32;
   localparam int unsigned ADDRESS_BITS = 32;
   localparam int unsigned FQ_DEPTH     = 4;

   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [ADDRESS_BITS-1:0] pc;
      logic [ILEN-1:0]         instr;
   } fq_entry_t;

   function automatic logic is_pow2_ge2(input int unsigned v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/fetch_queue_ff.sv
// Generic register with enable and asynchronous active-high reset.
// Used for the fetch queue pointers and occupancy counter.
module fetch_queue_ff #(
   parameter int unsigned     Width    = 1,
   parameter logic [Width-1:0] ResetVal = '0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             en_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         q_o <= ResetVal;
      end else if (en_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Circular {pc, instr} buffer between instruction fetch and decode.
// Flush discards all entries so wrong-path instructions never reach decode.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned Depth = FQ_DEPTH
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          enq_valid_i,
   input  logic [ILEN-1:0]               enq_instr_i,
   input  logic [ADDRESS_BITS-1:0]       enq_pc_i,
   output logic                          enq_ready_o,
   output logic                          deq_valid_o,
   output logic [ILEN-1:0]               deq_instr_o,
   output logic [ADDRESS_BITS-1:0]       deq_pc_o,
   input  logic                          deq_ready_i,
   input  logic                          flush_i,
   output logic [$clog2(Depth+1)-1:0]    count_o,
   output logic                          full_o,
   output logic                          empty_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);

   if (!is_pow2_ge2(Depth)) begin : g_depth_check
      $error("fetch_queue: Depth must be a power of two and >= 2");
   end

   fq_entry_t            mem_q [Depth];
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]      count_q, count_d;
   logic                 enq_fire, deq_fire;
   logic                 wr_ptr_en, rd_ptr_en;
   fq_entry_t            head;

   // Ready depends only on registered count: no deq_ready -> enq_ready path.
   assign full_o      = (count_q == CntW'(Depth));
   assign empty_o     = (count_q == '0);
   assign enq_ready_o = !full_o;
   assign deq_valid_o = !empty_o;
   assign count_o     = count_q;

   assign enq_fire = enq_valid_i && enq_ready_o;
   assign deq_fire = deq_valid_o && deq_ready_i;

   assign head        = mem_q[rd_ptr_q];
   assign deq_instr_o = empty_o ? NOP_INSTR : head.instr;
   assign deq_pc_o    = empty_o ? '0 : head.pc;

   always_comb begin
      wr_ptr_d  = wr_ptr_q + PtrW'(1);
      rd_ptr_d  = rd_ptr_q + PtrW'(1);
      wr_ptr_en = enq_fire;
      rd_ptr_en = deq_fire;
      count_d   = count_q;
      if (flush_i) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         wr_ptr_en = 1'b1;
         rd_ptr_en = 1'b1;
         count_d   = '0;
      end else begin
         unique case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   fetch_queue_ff #(.Width(PtrW)) u_wr_ptr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (wr_ptr_en),
      .d_i     (wr_ptr_d),
      .q_o     (wr_ptr_q)
   );

   fetch_queue_ff #(.Width(PtrW)) u_rd_ptr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (rd_ptr_en),
      .d_i     (rd_ptr_d),
      .q_o     (rd_ptr_q)
   );

   fetch_queue_ff #(.Width(CntW)) u_count (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (1'b1),
      .d_i     (count_d),
      .q_o     (count_q)
   );

   // Storage is intentionally not reset; entries past count are don't-care.
   always_ff @(posedge clk_i) begin
      if (enq_fire && !flush_i) begin
         mem_q[wr_ptr_q] <= '{pc: enq_pc_i, instr: enq_instr_i};
      end
   end

   assert property (@(posedge clk_i) disable iff (reset_i) count_q <= CntW'(Depth));
   assert property (@(posedge clk_i) disable iff (reset_i) !(full_o && empty_o));
   assert property (@(posedge clk_i) disable iff (reset_i)
                    (wr_ptr_q - rd_ptr_q) == PtrW'(count_q));

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: accepted entries are queued by the bench
// and compared against the head whenever decode consumes.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int unsigned DEPTH = FQ_DEPTH;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    enq_valid;
   logic [ILEN-1:0]         enq_instr;
   logic [ADDRESS_BITS-1:0] enq_pc;
   logic                    enq_ready;
   logic                    deq_valid;
   logic [ILEN-1:0]         deq_instr;
   logic [ADDRESS_BITS-1:0] deq_pc;
   logic                    deq_ready;
   logic                    flush;
   logic [CW-1:0]           count;
   logic                    full;
   logic                    empty;

   int checks   = 0;
   int failures = 0;
   fq_entry_t exp_q[$];

   always #5 clk = ~clk;

   fetch_queue #(.Depth(DEPTH)) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .enq_valid_i (enq_valid),
      .enq_instr_i (enq_instr),
      .enq_pc_i    (enq_pc),
      .enq_ready_o (enq_ready),
      .deq_valid_o (deq_valid),
      .deq_instr_o (deq_instr),
      .deq_pc_o    (deq_pc),
      .deq_ready_i (deq_ready),
      .flush_i     (flush),
      .count_o     (count),
      .full_o      (full),
      .empty_o     (empty)
   );

   function automatic logic [ILEN-1:0] mk_instr(input logic [ADDRESS_BITS-1:0] pc);
      return pc ^ 32'h5A00_0003;
   endfunction

   task automatic drive_enq(input logic v, input logic [ADDRESS_BITS-1:0] pc);
      enq_valid = v;
      enq_pc    = pc;
      enq_instr = mk_instr(pc);
   endtask

   // Advance one clock and update the reference queue from pre-edge inputs.
   task automatic tick();
      bit ef, df;
      fq_entry_t e;
      ef = enq_valid && (exp_q.size() < DEPTH);
      df = deq_ready && (exp_q.size() != 0);
      e  = '{pc: enq_pc, instr: enq_instr};
      @(posedge clk);
      if (flush) begin
         exp_q.delete();
      end else begin
         if (df) void'(exp_q.pop_front());
         if (ef) exp_q.push_back(e);
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive_enq(1'b0, '0);
      deq_ready = 1'b0;
      flush     = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      checks++;
      if (deq_valid !== 1'b0 || deq_instr !== NOP_INSTR || deq_pc !== '0 || count !== '0 ||
          enq_ready !== 1'b1 || full !== 1'b0 || empty !== 1'b1) begin
         failures++;
         $display("FAIL reset_outputs got v=%b i=%h pc=%h c=%0d r=%b f=%b e=%b", deq_valid,
                  deq_instr, deq_pc, count, enq_ready, full, empty);
      end
      for (int i = 0; i < 3; i++) begin
         drive_enq(1'b1, 32'h1000 + 4 * i);
         tick();
      end
      drive_enq(1'b0, '0);
      checks++;
      if (count !== CW'(3)) begin
         failures++;
         $display("FAIL pre_reset_count got %0d exp 3", count);
      end
      #1 reset = 1'b1;
      #1;
      exp_q.delete();
      checks++;
      if (deq_valid !== 1'b0 || deq_instr !== NOP_INSTR || count !== '0 || enq_ready !== 1'b1 ||
          empty !== 1'b1 || full !== 1'b0) begin
         failures++;
         $display("FAIL async_reset got v=%b i=%h c=%0d r=%b e=%b f=%b", deq_valid, deq_instr,
                  count, enq_ready, empty, full);
      end
      #2 reset = 1'b0;
      @(posedge clk);
      #1;
      drive_enq(1'b1, 32'h300);
      checks++;
      if (deq_valid !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_bypass got deq_valid=%b exp 0", deq_valid);
      end
      tick();
      drive_enq(1'b0, '0);
      checks++;
      if (deq_valid !== 1'b1 || deq_pc !== 32'h300 || deq_instr !== mk_instr(32'h300)) begin
         failures++;
         $display("FAIL post_reset_first got v=%b pc=%h i=%h exp pc=300", deq_valid, deq_pc,
                  deq_instr);
      end
      deq_ready = 1'b1;
      tick();
      deq_ready = 1'b0;
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 4; i++) begin
         drive_enq(1'b1, 32'(4 * i));
         tick();
      end
      checks++;
      if (full !== 1'b1 || enq_ready !== 1'b0 || count !== CW'(4) || empty !== 1'b0) begin
         failures++;
         $display("FAIL fill_full got full=%b rdy=%b count=%0d exp 1/0/4", full, enq_ready, count);
      end
      drive_enq(1'b1, 32'h10);
      tick();
      drive_enq(1'b0, '0);
      checks++;
      if (count !== CW'(4)) begin
         failures++;
         $display("FAIL fill_drop5 got count=%0d exp 4", count);
      end
      deq_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (exp_q.size() == 0 || deq_valid !== 1'b1 || deq_pc !== exp_q[0].pc ||
             deq_pc !== 32'(4 * i) || deq_instr !== exp_q[0].instr) begin
            failures++;
            $display("FAIL drain_pc[%0d] got v=%b pc=%h exp pc=%h", i, deq_valid, deq_pc,
                     32'(4 * i));
         end
         tick();
      end
      deq_ready = 1'b0;
      checks++;
      if (empty !== 1'b1 || count !== '0 || deq_valid !== 1'b0) begin
         failures++;
         $display("FAIL drain_empty got empty=%b count=%0d exp 1/0", empty, count);
      end
   endtask

   task automatic test_full_simul();
      for (int i = 0; i < 4; i++) begin
         drive_enq(1'b1, 32'h50 + 4 * i);
         tick();
      end
      drive_enq(1'b1, 32'h60);
      deq_ready = 1'b1;
      checks++;
      if (enq_ready !== 1'b0 || deq_pc !== 32'h50) begin
         failures++;
         $display("FAIL full_simul_ready got rdy=%b pc=%h exp 0/50", enq_ready, deq_pc);
      end
      tick();
      deq_ready = 1'b0;
      checks++;
      if (count !== CW'(3)) begin
         failures++;
         $display("FAIL full_simul_deq_only got count=%0d exp 3", count);
      end
      tick();
      drive_enq(1'b0, '0);
      checks++;
      if (count !== CW'(4) || full !== 1'b1) begin
         failures++;
         $display("FAIL full_simul_refill got count=%0d full=%b exp 4/1", count, full);
      end
      deq_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (exp_q.size() == 0 || deq_pc !== exp_q[0].pc || deq_pc !== 32'h54 + 4 * i) begin
            failures++;
            $display("FAIL full_simul_drain[%0d] got pc=%h exp %h", i, deq_pc, 32'h54 + 4 * i);
         end
         tick();
      end
      deq_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 2; i++) begin
         drive_enq(1'b1, 32'(4 * i));
         tick();
      end
      deq_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_enq(1'b1, 32'h8 + 4 * i);
         checks++;
         if (count !== CW'(2) || exp_q.size() == 0 || deq_pc !== exp_q[0].pc ||
             deq_pc !== 32'(4 * i) || deq_instr !== mk_instr(32'(4 * i))) begin
            failures++;
            $display("FAIL b2b[%0d] got count=%0d pc=%h exp 2/%h", i, count, deq_pc, 32'(4 * i));
         end
         tick();
      end
      drive_enq(1'b0, '0);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (exp_q.size() == 0 || deq_pc !== exp_q[0].pc || deq_pc !== 32'h28 + 4 * i) begin
            failures++;
            $display("FAIL b2b_tail[%0d] got pc=%h exp %h", i, deq_pc, 32'h28 + 4 * i);
         end
         tick();
      end
      deq_ready = 1'b0;
      checks++;
      if (empty !== 1'b1) begin
         failures++;
         $display("FAIL b2b_empty got empty=%b exp 1", empty);
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive_enq(1'b1, 32'h80 + 4 * i);
         tick();
      end
      drive_enq(1'b1, 32'h100);
      deq_ready = 1'b1;
      flush     = 1'b1;
      tick();
      flush     = 1'b0;
      deq_ready = 1'b0;
      drive_enq(1'b0, '0);
      checks++;
      if (count !== '0 || empty !== 1'b1 || deq_valid !== 1'b0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL flush_clear got count=%0d empty=%b v=%b exp 0/1/0", count, empty,
                  deq_valid);
      end
      drive_enq(1'b1, 32'h200);
      tick();
      drive_enq(1'b0, '0);
      checks++;
      if (exp_q.size() == 0 || deq_valid !== 1'b1 || deq_pc !== exp_q[0].pc ||
          deq_pc !== 32'h200) begin
         failures++;
         $display("FAIL flush_first_after got v=%b pc=%h exp pc=200", deq_valid, deq_pc);
      end
      deq_ready = 1'b1;
      tick();
      tick();
      deq_ready = 1'b0;
      checks++;
      if (count !== '0 || empty !== 1'b1) begin
         failures++;
         $display("FAIL deq_while_empty got count=%0d empty=%b exp 0/1", count, empty);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (count !== '0 || empty !== 1'b1 || enq_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_empty got count=%0d empty=%b rdy=%b exp 0/1/1", count, empty,
                  enq_ready);
      end
   endtask

   task automatic test_latency();
      drive_enq(1'b1, 32'h40);
      deq_ready = 1'b1;
      checks++;
      if (deq_valid !== 1'b0 || deq_instr !== NOP_INSTR) begin
         failures++;
         $display("FAIL latency_n got v=%b i=%h exp 0/00000013", deq_valid, deq_instr);
      end
      tick();
      drive_enq(1'b0, '0);
      checks++;
      if (deq_valid !== 1'b1 || deq_pc !== 32'h40) begin
         failures++;
         $display("FAIL latency_n1 got v=%b pc=%h exp 1/40", deq_valid, deq_pc);
      end
      tick();
      deq_ready = 1'b0;
      checks++;
      if (empty !== 1'b1 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL latency_n2 got empty=%b exp 1", empty);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_fill_drain();
      test_full_simul();
      test_back_to_back();
      test_flush();
      test_latency();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
